arb_mux_nway: RTL and testbench
===============================

ARB_MUX_NWAY -- requirements
Module: arb_mux_nway

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, bit width of each channel word.
REQ-002 The block SHALL have parameter CHANNELS, default 8, number of input channels (2..32).
REQ-003 The block SHALL have parameter MODE, default 1, channel-select policy: 0 = SEL (external select), 1 = RR (round-robin).
REQ-004 The block SHALL use one clock and an asynchronous active-low reset, with ports clk and rst_n.
REQ-005 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-006 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port in_valid, input, CHANNELS bits: per-channel word-valid flags.
REQ-008 Port in_data, input, CHANNELS*WIDTH bits: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 Port in_ready, output, CHANNELS bits: per-channel accept flag, at most one bit set.
REQ-010 Port sel, input, SELW = max(1, clog2(CHANNELS)) bits: channel index used in MODE 0; ignored in MODE 1.
REQ-011 Port out_valid, output, 1 bit: output register holds a word.
REQ-012 Port out_data, output, WIDTH bits: selected word.
REQ-013 Port out_chan, output, SELW bits: index of the source channel of out_data.
REQ-014 Port out_ready, input, 1 bit: downstream accepts the word.

Function
REQ-015 The block SHALL define slot_free = !out_valid || out_ready.
REQ-016 A transfer SHALL occur on channel k when in_valid[k] && in_ready[k] at a rising clk edge.
REQ-017 MODE 0: in_ready SHALL equal one-hot(sel) ANDed with slot_free; sel >= CHANNELS SHALL yield in_ready = 0.
REQ-018 MODE 1: the grant SHALL be the lowest index at or after rr_ptr, wrapping modulo CHANNELS, whose in_valid is set; in_ready SHALL equal one-hot(grant) ANDed with slot_free.
REQ-019 MODE 1: after a transfer on channel g, rr_ptr SHALL become (g+1) mod CHANNELS; CHANNELS-1 SHALL wrap to 0.
REQ-020 rr_ptr SHALL hold its value when no transfer occurs.
REQ-021 in_ready SHALL be combinational from in_valid, sel, rr_ptr, out_valid and out_ready; in_ready SHALL NOT depend on in_data.
REQ-022 On a transfer, out_data and out_chan SHALL load the granted word and index on that edge, and out_valid SHALL be 1 on the next cycle (latency 1).
REQ-023 When out_valid && out_ready and no transfer occurs, out_valid SHALL clear on that edge.
REQ-024 When out_valid && !out_ready, out_valid, out_data and out_chan SHALL hold stable and in_ready SHALL be 0.
REQ-025 Simultaneous downstream pop and upstream transfer in one cycle SHALL keep out_valid = 1 with the new word; throughput SHALL be 1 word per cycle.
REQ-026 When no in_valid is set (or the MODE 0 selected channel is not valid), in_ready SHALL still follow REQ-017 or REQ-018, and no transfer SHALL occur.
REQ-027 out_data and out_chan SHALL hold their last value while out_valid = 0.

Reset
REQ-028 While rst_n = 0: out_valid = 0, out_data = 0, out_chan = 0, rr_ptr = 0.
REQ-029 While rst_n = 0: in_ready SHALL be 0.
REQ-030 Reset asserted mid-stream SHALL discard the held word; the first grant after release in MODE 1 SHALL start search at channel 0.

Structure
REQ-031 Package arb_mux_pkg SHALL hold the MODE_SEL = 0 and MODE_RR = 1 constants.
REQ-032 The round-robin grant logic SHALL be one sub-module, rr_arbiter. It SHALL take the request vector, the pointer and an advance strobe, and return a one-hot grant and a grant index.
REQ-033 The output register and handshake SHALL reside in arb_mux_nway.

Verification
REQ-034 The bench SHALL cover these directed scenarios, each with the stated stimulus and required response:
- MODE 0, sel = 3, in_valid = 8'hFF, ch3 = 16'hBEEF, out_ready = 1 -> in_ready = 8'h08; next cycle out_valid = 1, out_data = 16'hBEEF, out_chan = 3.
- MODE 1, in_valid = 8'hFF held, out_ready = 1 -> out_chan sequence 0,1,...,7,0: pointer wraps and every cycle carries a word.
- MODE 1, rr_ptr = 6, in_valid = 8'b0000_0101 -> grant ch0, then ch2, then ch0; channels 6 and 7 are skipped.
- out_ready = 0 for 4 cycles with out_valid = 1 -> out_data and out_chan stable, in_ready = 0; out_ready = 1 -> a new word loads in the same cycle.
- rst_n pulsed low mid-stream with out_valid = 1 -> out_valid = 0 immediately (asynchronous); after release, first MODE 1 grant is the lowest valid index >= 0.
- MODE 0, CHANNELS = 6, sel = 7 -> in_ready = 0 and out_valid stays 0.

Source files
------------

// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the N-way arbitrating output mux.
package arb_mux_pkg;

  localparam int unsigned MODE_SEL = 0;
  localparam int unsigned MODE_RR  = 1;

  // Channel-index width, never below one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester at or after ptr, wrapping; also computes the next pointer.
module rr_arbiter #(
  parameter int unsigned N  = 8,
  parameter int unsigned IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic [IW-1:0] ptr_next
);

  logic        found;
  logic [31:0] c;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    c         = '0;
    for (int unsigned i = 0; i < N; i++) begin
      c = (32'(ptr) + i) % N;
      if (!found && req[c[IW-1:0]]) begin
        found                = 1'b1;
        grant[c[IW-1:0]]     = 1'b1;
        grant_idx            = c[IW-1:0];
      end
    end
  end

  always_comb begin
    ptr_next = ptr;
    if (advance) begin
      ptr_next = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/arb_mux_nway.sv
// N-way channel mux with external-select or round-robin policy and a single output register.
module arb_mux_nway
  import arb_mux_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned MODE     = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [CHANNELS-1:0]                 in_valid,
  input  logic [CHANNELS*WIDTH-1:0]           in_data,
  output logic [CHANNELS-1:0]                 in_ready,
  input  logic [sel_width(CHANNELS)-1:0]      sel,
  output logic                                out_valid,
  output logic [WIDTH-1:0]                    out_data,
  output logic [sel_width(CHANNELS)-1:0]      out_chan,
  input  logic                                out_ready
);

  localparam int unsigned SelW = sel_width(CHANNELS);

  logic                out_valid_q;
  logic [WIDTH-1:0]    out_data_q;
  logic [SelW-1:0]     out_chan_q;
  logic [SelW-1:0]     rr_ptr_q;
  logic [SelW-1:0]     rr_ptr_d;

  logic                slot_free;
  logic                xfer;
  logic                advance;
  logic [CHANNELS-1:0] sel_oh;
  logic [CHANNELS-1:0] arb_grant;
  logic [SelW-1:0]     arb_idx;
  logic [WIDTH-1:0]    word;
  logic [SelW-1:0]     chan;

  assign slot_free = !out_valid_q || out_ready;
  assign xfer      = |(in_valid & in_ready);
  assign advance   = xfer && (MODE == MODE_RR);

  rr_arbiter #(
    .N  (CHANNELS),
    .IW (SelW)
  ) u_rr_arbiter (
    .req       (in_valid),
    .ptr       (rr_ptr_q),
    .advance   (advance),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .ptr_next  (rr_ptr_d)
  );

  // Out-of-range sel matches no channel, so in_ready stays all-zero.
  always_comb begin
    sel_oh = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      sel_oh[k] = (sel == SelW'(k));
    end
  end

  always_comb begin
    in_ready = '0;
    if (rst_n && slot_free) begin
      in_ready = (MODE == MODE_RR) ? arb_grant : sel_oh;
    end
  end

  always_comb begin
    word = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (in_ready[k]) word = word | in_data[k*WIDTH +: WIDTH];
    end
    chan = (MODE == MODE_RR) ? arb_idx : sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= word;
        out_chan_q  <= chan;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_arb_mux_nway.sv
// Directed bench: select mode (8 and 6 channels) and round-robin mode (8 channels).
module tb_arb_mux_nway;

  logic clk;
  logic rst_n;

  // Select-mode, 8 channels
  logic [7:0]   s8_valid;
  logic [127:0] s8_data;
  logic [7:0]   s8_ready;
  logic [2:0]   s8_sel;
  logic         s8_ovalid;
  logic [15:0]  s8_odata;
  logic [2:0]   s8_ochan;
  logic         s8_oready;

  // Round-robin mode, 8 channels
  logic [7:0]   rr_valid;
  logic [127:0] rr_data;
  logic [7:0]   rr_ready;
  logic [2:0]   rr_sel;
  logic         rr_ovalid;
  logic [15:0]  rr_odata;
  logic [2:0]   rr_ochan;
  logic         rr_oready;

  // Select-mode, 6 channels
  logic [5:0]   s6_valid;
  logic [95:0]  s6_data;
  logic [5:0]   s6_ready;
  logic [2:0]   s6_sel;
  logic         s6_ovalid;
  logic [15:0]  s6_odata;
  logic [2:0]   s6_ochan;
  logic         s6_oready;

  int vectors;
  int miscompares;

  arb_mux_nway #(.WIDTH(16), .CHANNELS(8), .MODE(0)) u_sel8 (
    .clk(clk), .rst_n(rst_n), .in_valid(s8_valid), .in_data(s8_data), .in_ready(s8_ready),
    .sel(s8_sel), .out_valid(s8_ovalid), .out_data(s8_odata), .out_chan(s8_ochan),
    .out_ready(s8_oready)
  );

  arb_mux_nway #(.WIDTH(16), .CHANNELS(8), .MODE(1)) u_rr8 (
    .clk(clk), .rst_n(rst_n), .in_valid(rr_valid), .in_data(rr_data), .in_ready(rr_ready),
    .sel(rr_sel), .out_valid(rr_ovalid), .out_data(rr_odata), .out_chan(rr_ochan),
    .out_ready(rr_oready)
  );

  arb_mux_nway #(.WIDTH(16), .CHANNELS(6), .MODE(0)) u_sel6 (
    .clk(clk), .rst_n(rst_n), .in_valid(s6_valid), .in_data(s6_data), .in_ready(s6_ready),
    .sel(s6_sel), .out_valid(s6_ovalid), .out_data(s6_odata), .out_chan(s6_ochan),
    .out_ready(s6_oready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    s8_valid = '0; s8_sel = '0; s8_oready = 1'b0;
    rr_valid = 8'hFF; rr_sel = '0; rr_oready = 1'b1;
    s6_valid = '0; s6_sel = '0; s6_oready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      s8_data[k*16 +: 16] = 16'h1100 + 16'(k);
      rr_data[k*16 +: 16] = 16'hA000 + 16'(k);
    end
    s8_data[3*16 +: 16] = 16'hBEEF;
    for (int k = 0; k < 6; k++) s6_data[k*16 +: 16] = 16'h6600 + 16'(k);

    // Reset state, with requests pending
    tick;
    tick;
    check("rst_ovalid", 32'(rr_ovalid), 32'h0);
    check("rst_odata", 32'(rr_odata), 32'h0);
    check("rst_ochan", 32'(rr_ochan), 32'h0);
    check("rst_ready", 32'(rr_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rr_valid = 8'h00;

    // Select mode, sel = 3
    s8_sel = 3'd3; s8_valid = 8'hFF; s8_oready = 1'b1;
    #1;
    check("sel_ready", 32'(s8_ready), 32'h08);
    tick;
    check("sel_ovalid", 32'(s8_ovalid), 32'h1);
    check("sel_odata", 32'(s8_odata), 32'hBEEF);
    check("sel_ochan", 32'(s8_ochan), 32'h3);
    s8_valid = 8'h00;
    #1;
    check("sel_ready_novalid", 32'(s8_ready), 32'h08);
    tick;
    check("sel_drain_ovalid", 32'(s8_ovalid), 32'h0);
    check("sel_hold_odata", 32'(s8_odata), 32'hBEEF);

    // Six channels, out-of-range select
    s6_sel = 3'd7; s6_valid = 6'h3F; s6_oready = 1'b1;
    #1;
    check("sel6_oob_ready", 32'(s6_ready), 32'h0);
    tick;
    check("sel6_oob_ovalid", 32'(s6_ovalid), 32'h0);
    s6_sel = 3'd5;
    #1;
    check("sel6_ch5_ready", 32'(s6_ready), 32'h20);
    s6_valid = 6'h00;

    // Round-robin, all channels valid: 0..7 then wrap to 0
    rr_valid = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      #1;
      check("rr_all_ready", 32'(rr_ready), 32'(8'h01 << (i % 8)));
      tick;
      check("rr_all_ovalid", 32'(rr_ovalid), 32'h1);
      check("rr_all_ochan", 32'(rr_ochan), 32'(i % 8));
      check("rr_all_odata", 32'(rr_odata), 32'h0000A000 + 32'(i % 8));
    end

    // Pointer is 1; a ch5 transfer moves it to 6
    rr_valid = 8'b0010_0000;
    tick;
    check("rr_ch5_ochan", 32'(rr_ochan), 32'h5);
    rr_valid = 8'b0000_0101;
    #1;
    check("rr_skip_ready0", 32'(rr_ready), 32'h01);
    tick;
    check("rr_skip_ochan0", 32'(rr_ochan), 32'h0);
    check("rr_skip_ready1", 32'(rr_ready), 32'h04);
    tick;
    check("rr_skip_ochan1", 32'(rr_ochan), 32'h2);
    check("rr_skip_ready2", 32'(rr_ready), 32'h01);
    tick;
    check("rr_skip_ochan2", 32'(rr_ochan), 32'h0);

    // Backpressure: word held, no grants; pointer is 1
    rr_valid = 8'hFF; rr_oready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("stall_ready", 32'(rr_ready), 32'h0);
      tick;
      check("stall_ovalid", 32'(rr_ovalid), 32'h1);
      check("stall_ochan", 32'(rr_ochan), 32'h0);
      check("stall_odata", 32'(rr_odata), 32'h0000A000);
    end
    rr_oready = 1'b1;
    #1;
    check("unstall_ready", 32'(rr_ready), 32'h02);
    tick;
    check("unstall_ovalid", 32'(rr_ovalid), 32'h1);
    check("unstall_ochan", 32'(rr_ochan), 32'h1);
    check("unstall_odata", 32'(rr_odata), 32'h0000A001);

    // Asynchronous reset mid-stream; pointer was 2, must restart at 0
    #2;
    rst_n = 1'b0;
    #1;
    check("async_ovalid", 32'(rr_ovalid), 32'h0);
    check("async_ochan", 32'(rr_ochan), 32'h0);
    check("async_odata", 32'(rr_odata), 32'h0);
    check("async_ready", 32'(rr_ready), 32'h0);
    rr_valid = 8'b0000_1010;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(rr_ready), 32'h02);
    tick;
    check("post_rst_ochan", 32'(rr_ochan), 32'h1);
    check("post_rst_odata", 32'(rr_odata), 32'h0000A001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
